// File: rtl/div_arbiter_pkg.sv
// Shared types and the round-robin search used by the divider arbiter.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  localparam int unsigned MaxReq  = 16;
  localparam int unsigned MaxIdxW = 4;

  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } rr_result_t;

  // First set bit of req_vector at or after ptr, wrapping at num_req.
  function automatic rr_result_t next_rr(input logic [MaxReq-1:0]  req_vector,
                                         input logic [MaxIdxW-1:0] ptr,
                                         input int unsigned        num_req);
    rr_result_t res;
    logic [MaxIdxW:0] cand;
    res = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      cand = {1'b0, ptr} + 5'(k);
      if (cand >= 5'(num_req)) cand = cand - 5'(num_req);
      if (k < num_req && !res.found && req_vector[cand[MaxIdxW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MaxIdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin priority select starting at ptr.
module rr_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant_onehot,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                any_grant
);

  rr_result_t res;

  always_comb begin
    res          = next_rr(MaxReq'(req), MaxIdxW'(ptr), NUM_REQ);
    any_grant    = res.found;
    grant_idx    = ID_WIDTH'(res.idx);
    grant_onehot = '0;
    if (res.found) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one multi-cycle signed divider; one request in flight at a time.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_num,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_den,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_quotient,
  output logic [DATA_WIDTH-1:0]         rsp_remainder,
  output logic                          rsp_error,
  output logic                          div_start,
  output logic [DATA_WIDTH-1:0]         div_numerator,
  output logic [DATA_WIDTH-1:0]         div_denominator,
  input  logic [DATA_WIDTH-1:0]         div_quotient,
  input  logic [DATA_WIDTH-1:0]         div_remainder,
  input  logic                          div_error,
  input  logic                          div_done,
  output logic                          busy
);

  state_t                state_q;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DATA_WIDTH-1:0] num_q, den_q, quot_q, rem_q;
  logic                  err_q, start_q, valid_q, busy_q;

  logic [NUM_REQ-1:0]    grant_onehot;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  any_grant;
  logic [DATA_WIDTH-1:0] sel_num, sel_den;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req          (req_valid),
    .ptr          (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_grant    (any_grant)
  );

  always_comb begin
    sel_num = '0;
    sel_den = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_num = req_num[i*DATA_WIDTH +: DATA_WIDTH];
        sel_den = req_den[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grant is visible in the accept cycle; masked during reset so it reads zero.
  assign req_ready = (state_q == IDLE && !reset) ? grant_onehot : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      num_q   <= '0;
      den_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_grant) begin
            num_q   <= sel_num;
            den_q   <= sel_den;
            id_q    <= grant_idx;
            ptr_q   <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: state_q <= WAIT;
        WAIT: begin
          if (div_done) begin
            quot_q  <= div_quotient;
            rem_q   <= div_remainder;
            err_q   <= div_error;
            valid_q <= 1'b1;
            state_q <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid       = valid_q;
  assign rsp_id          = id_q;
  assign rsp_quotient    = quot_q;
  assign rsp_remainder   = rem_q;
  assign rsp_error       = err_q;
  assign div_start       = start_q;
  assign div_numerator   = num_q;
  assign div_denominator = den_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a latency-programmable divider model.
module tb_div_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_num, req_den;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_quotient, rsp_remainder;
  logic              rsp_error;
  logic              div_start;
  logic [DW-1:0]     div_numerator, div_denominator;
  logic [DW-1:0]     div_quotient, div_remainder;
  logic              div_error, div_done;
  logic              busy;

  logic [DW-1:0]     op_n [NR];
  logic [DW-1:0]     op_d [NR];
  int                n_cmp = 0;
  int                n_fail = 0;
  int                exp_ptr = 0;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_num[g*DW +: DW] = op_n[g];
    assign req_den[g*DW +: DW] = op_d[g];
  end

  div_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_num         (req_num),
    .req_den         (req_den),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_quotient    (rsp_quotient),
    .rsp_remainder   (rsp_remainder),
    .rsp_error       (rsp_error),
    .div_start       (div_start),
    .div_numerator   (div_numerator),
    .div_denominator (div_denominator),
    .div_quotient    (div_quotient),
    .div_remainder   (div_remainder),
    .div_error       (div_error),
    .div_done        (div_done),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  // Divider model: done arrives div_dly+1 cycles after the start cycle, operands read at completion.
  int          div_dly = 3;
  int          mdl_cnt;
  logic        mdl_done, mdl_err;
  logic [DW-1:0] mdl_q, mdl_r;
  logic        spur = 1'b0;

  assign div_done      = mdl_done | spur;
  assign div_quotient  = spur ? 32'hDEAD_BEEF : mdl_q;
  assign div_remainder = spur ? 32'h5A5A_5A5A : mdl_r;
  assign div_error     = spur ? 1'b1 : mdl_err;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mdl_cnt <= 0; mdl_done <= 1'b0; mdl_q <= '0; mdl_r <= '0; mdl_err <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (div_start) mdl_cnt <= div_dly;
      else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) begin
          mdl_done <= 1'b1;
          if (div_denominator == '0) begin
            mdl_q <= '1; mdl_r <= div_numerator; mdl_err <= 1'b1;
          end else begin
            mdl_q   <= $signed(div_numerator) / $signed(div_denominator);
            mdl_r   <= $signed(div_numerator) % $signed(div_denominator);
            mdl_err <= 1'b0;
          end
        end
      end
    end
  end

  // Reference arithmetic: truncating division on wide integers, remainder by n - q*d.
  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] n, input logic [DW-1:0] d);
    longint a, b;
    a = longint'(signed'(n)); b = longint'(signed'(d));
    return DW'(a / b);
  endfunction

  function automatic logic [DW-1:0] ref_r(input logic [DW-1:0] n, input logic [DW-1:0] d);
    longint a, b;
    a = longint'(signed'(n)); b = longint'(signed'(d));
    return DW'(a - (a / b) * b);
  endfunction

  function automatic int ref_grant(input logic [NR-1:0] mask, input int ptr);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (ptr + k) % NR;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  // Issue a request from an IDLE negedge; returns at the negedge where rsp_valid is seen.
  task automatic txn(input logic [NR-1:0] mask, input int dly, input bit hold,
                     output logic [NR-1:0] rdy, output int grant, output int lat,
                     output int starts);
    int w;
    grant = -1; lat = -1; starts = 0; rdy = '0; div_dly = dly;
    req_valid = mask;
    #1;
    w = 0;
    while (req_ready == '0 && w < 20) begin @(negedge clock); w++; end
    rdy = req_ready;
    if (req_ready == '0) begin req_valid = '0; return; end
    for (int i = 0; i < NR; i++) if (req_ready[i]) grant = i;
    @(negedge clock);
    if (!hold) req_valid = '0;
    if (!div_start) return;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge clock);
      lat++;
      if (div_start) starts++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1;
    @(negedge clock);
    n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_error, busy, div_start} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_error, busy, div_start}); end
    n_cmp++; if ({rsp_id, rsp_quotient, rsp_remainder, div_numerator, div_denominator} !== '0) begin n_fail++; $display("FAIL reset_data: got nonzero want 0"); end
    req_valid = '0; reset = 1'b0;
    @(negedge clock);
    req_valid = '1; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_before_accept_busy: got %b want 0", busy); end
    exp_ptr = 0;
  endtask

  task automatic test_single();
    logic [NR-1:0] rdy; int g, lat, st;
    op_n[2] = 32'd100; op_d[2] = 32'd7; rsp_ready = 1'b1;
    txn(4'b0100, 4, 1'b0, rdy, g, lat, st);
    n_cmp++; if (rdy !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", rdy); end
    n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL single_latency: got %0d want 6", lat); end
    n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL single_extra_start: got %0d want 0", st); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_quotient !== 32'd14) begin n_fail++; $display("FAIL single_quot: got %h want %h", rsp_quotient, 32'd14); end
    n_cmp++; if (rsp_remainder !== 32'd2) begin n_fail++; $display("FAIL single_rem: got %h want %h", rsp_remainder, 32'd2); end
    n_cmp++; if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", rsp_error); end
    @(negedge clock);
    n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b want 00", {rsp_valid, busy}); end
    exp_ptr = 3;
  endtask

  task automatic test_signed();
    logic [NR-1:0] rdy; int g, lat, st;
    op_n[0] = -32'sd100; op_d[0] = 32'd7;
    txn(4'b0001, 2, 1'b0, rdy, g, lat, st);
    n_cmp++; if (g !== 0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL signed_id: got %0d/%0d want 0", g, rsp_id); end
    n_cmp++; if (rsp_quotient !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL signed_quot: got %h want FFFFFFF2", rsp_quotient); end
    n_cmp++; if (rsp_remainder !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL signed_rem: got %h want FFFFFFFE", rsp_remainder); end
    @(negedge clock);
    exp_ptr = 1;
  endtask

  task automatic test_div_zero();
    logic [NR-1:0] rdy; int g, lat, st;
    op_n[1] = 32'd5; op_d[1] = 32'd0;
    txn(4'b0010, 3, 1'b0, rdy, g, lat, st);
    n_cmp++; if (rsp_error !== 1'b1) begin n_fail++; $display("FAIL dz_err: got %b want 1", rsp_error); end
    n_cmp++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL dz_id: got %0d want 1", rsp_id); end
    n_cmp++; if (rsp_quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_passthru: got %h want FFFFFFFF", rsp_quotient); end
    @(negedge clock);
    n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL dz_idle: got %b want 00", {rsp_valid, busy}); end
    exp_ptr = 2;
  endtask

  task automatic test_fairness();
    logic [NR-1:0] rdy; int g, lat, st;
    reset = 1'b1; @(negedge clock); reset = 1'b0; @(negedge clock);
    for (int k = 0; k < NR; k++) begin op_n[k] = DW'(k * 10); op_d[k] = 32'd3; end
    for (int t = 0; t < 5; t++) begin
      txn(4'b1111, 1 + t, 1'b1, rdy, g, lat, st);
      n_cmp++; if (g !== t % NR) begin n_fail++; $display("FAIL fair_grant%0d: got %0d want %0d", t, g, t % NR); end
      n_cmp++; if ($countones(rdy) !== 1) begin n_fail++; $display("FAIL fair_onehot%0d: got %b want one bit", t, rdy); end
      n_cmp++; if (rsp_id !== IW'(t % NR)) begin n_fail++; $display("FAIL fair_id%0d: got %0d want %0d", t, rsp_id, t % NR); end
      n_cmp++; if (rsp_quotient !== ref_q(op_n[t % NR], 32'd3)) begin n_fail++; $display("FAIL fair_quot%0d: got %h want %h", t, rsp_quotient, ref_q(op_n[t % NR], 32'd3)); end
      @(negedge clock);
    end
    req_valid = '0;
    exp_ptr = 1;
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] rdy; int g, lat, st;
    logic [DW-1:0] eq, er;
    op_n[3] = 32'd77; op_d[3] = -32'sd5;
    eq = ref_q(op_n[3], op_d[3]); er = ref_r(op_n[3], op_d[3]);
    @(negedge clock);
    spur = 1'b1; @(negedge clock); spur = 1'b0;
    n_cmp++; if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL idle_spurious_done: got %b want 00", {busy, rsp_valid}); end
    rsp_ready = 1'b0;
    txn(4'b1000, 2, 1'b0, rdy, g, lat, st);
    req_valid = 4'b0111;
    for (int c = 0; c < 20; c++) begin
      spur = (c % 3 == 0);
      @(negedge clock);
      n_cmp++; if ({rsp_valid, rsp_id, rsp_error} !== {1'b1, 2'd3, 1'b0}) begin n_fail++; $display("FAIL bp_ctrl%0d: got %b/%0d/%b want 1/3/0", c, rsp_valid, rsp_id, rsp_error); end
      n_cmp++; if ({rsp_quotient, rsp_remainder} !== {eq, er}) begin n_fail++; $display("FAIL bp_data%0d: got %h/%h want %h/%h", c, rsp_quotient, rsp_remainder, eq, er); end
      n_cmp++; if ({req_ready, div_start} !== 5'b0) begin n_fail++; $display("FAIL bp_quiet%0d: got %b/%b want 0/0", c, req_ready, div_start); end
    end
    spur = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    req_valid = '0;
    @(negedge clock); @(negedge clock);
    n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL bp_single_rsp: got %b want 00", {rsp_valid, busy}); end
    exp_ptr = 0;
  endtask

  task automatic test_reset_mid_wait();
    logic [NR-1:0] rdy; int g, lat, st; int seen;
    op_n[1] = 32'd50; op_d[1] = 32'd6; div_dly = 10;
    req_valid = 4'b0010;
    @(negedge clock);
    req_valid = '0;
    n_cmp++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL rmw_start: got %b want 1", div_start); end
    @(negedge clock); @(negedge clock);
    reset = 1'b1; #1;
    n_cmp++; if ({rsp_valid, busy, div_start, rsp_error, req_ready} !== 8'b0) begin n_fail++; $display("FAIL rmw_flags: got %b want 0", {rsp_valid, busy, div_start, rsp_error, req_ready}); end
    n_cmp++; if ({rsp_id, rsp_quotient, div_numerator, div_denominator} !== '0) begin n_fail++; $display("FAIL rmw_data: got nonzero want 0"); end
    @(negedge clock); reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin @(negedge clock); if (rsp_valid || busy) seen++; end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rmw_no_rsp: got %0d want 0", seen); end
    req_valid = '1; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmw_ptr0: got %b want 0001", req_ready); end
    req_valid = '0;
    op_n[0] = 32'd9; op_d[0] = 32'd4;
    txn(4'b0001, 3, 1'b0, rdy, g, lat, st);
    n_cmp++; if ({rsp_id, rsp_quotient, rsp_remainder} !== {2'd0, 32'd2, 32'd1}) begin n_fail++; $display("FAIL rmw_after: got %0d/%h/%h want 0/2/1", rsp_id, rsp_quotient, rsp_remainder); end
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL rmw_latency: got %0d want 5", lat); end
    @(negedge clock);
    exp_ptr = 1;
  endtask

  task automatic test_random();
    logic [NR-1:0] rdy, mask; int g, lat, st, eg, dly;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NR; k++) begin
        op_n[k] = DW'(int'($urandom_range(0, 2000000)) - 1000000);
        op_d[k] = ($urandom_range(0, 7) == 0) ? '0 : DW'(int'($urandom_range(1, 2000)) - 1000);
        if (op_d[k] == '0 && $urandom_range(0, 1) == 0) op_d[k] = 32'd1;
      end
      mask = NR'($urandom_range(1, 15));
      dly = int'($urandom_range(1, 6));
      eg = ref_grant(mask, exp_ptr);
      rsp_ready = $urandom_range(0, 1) == 1;
      txn(mask, dly, 1'b0, rdy, g, lat, st);
      n_cmp++; if (g !== eg || rsp_id !== IW'(eg)) begin n_fail++; $display("FAIL rnd_grant%0d: got %0d/%0d want %0d", t, g, rsp_id, eg); end
      n_cmp++; if (lat !== dly + 2) begin n_fail++; $display("FAIL rnd_latency%0d: got %0d want %0d", t, lat, dly + 2); end
      if (op_d[eg] == '0) begin
        n_cmp++; if (rsp_error !== 1'b1) begin n_fail++; $display("FAIL rnd_dz%0d: got %b want 1", t, rsp_error); end
      end else begin
        n_cmp++; if ({rsp_error, rsp_quotient, rsp_remainder} !== {1'b0, ref_q(op_n[eg], op_d[eg]), ref_r(op_n[eg], op_d[eg])}) begin
          n_fail++; $display("FAIL rnd_result%0d: got %b/%h/%h want 0/%h/%h", t, rsp_error, rsp_quotient, rsp_remainder, ref_q(op_n[eg], op_d[eg]), ref_r(op_n[eg], op_d[eg]));
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      rsp_ready = 1'b1;
      @(negedge clock);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_handshake%0d: got %b want 0", t, rsp_valid); end
      exp_ptr = (eg + 1) % NR;
    end
  endtask

  initial begin
    for (int k = 0; k < NR; k++) begin op_n[k] = '0; op_d[k] = 32'd1; end
    test_reset();
    test_single();
    test_signed();
    test_div_zero();
    test_fairness();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one multi-cycle signed integer divider among NUM_REQ requesters in the FM radio datapath, such as the demodulator and the de-emphasis/gain stages. It selects requests round-robin, launches the divider with a one-cycle start pulse, and holds the operands stable while the divider runs. When the divider finishes, it returns the tagged quotient, remainder and error on a shared valid/ready response channel.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, operand/result width, two's complement
- ID_WIDTH, $clog2(NUM_REQ), requester tag width
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_num  in  NUM_REQ×DATA_WIDTH  packed dividends
- req_den  in  NUM_REQ×DATA_WIDTH  packed divisors
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_WIDTH  index of the requester that owns the response
- rsp_quotient  out  DATA_WIDTH  signed quotient
- rsp_remainder  out  DATA_WIDTH  signed remainder (sign of dividend)
- rsp_error  out  1  divide-by-zero flag from the divider
- div_start  out  1  one-cycle launch pulse to the divider
- div_numerator  out  DATA_WIDTH  registered dividend to the divider
- div_denominator  out  DATA_WIDTH  registered divisor to the divider
- div_quotient  in  DATA_WIDTH  divider quotient, valid when div_done=1
- div_remainder  in  DATA_WIDTH  divider remainder, valid when div_done=1
- div_error  in  1  divider error, valid when div_done=1
- div_done  in  1  divider completion pulse
- busy  out  1  high in every state except IDLE

## Operation
- **FSM states:** IDLE, LAUNCH, WAIT, RESPOND.
- **IDLE:**
  - Grant logic: if any req_valid, grant the first valid index at or after ptr, searching upward modulo NUM_REQ.
  - Accept: req_ready[g] is high combinationally in the same cycle. On that edge, latch req_num[g]/req_den[g] into div_numerator/div_denominator, latch g into the ID register, set ptr=(g+1) mod NUM_REQ, and go to LAUNCH.
- **LAUNCH:** div_start=1 for exactly this cycle → WAIT.
- **WAIT:**
  - When div_done=1, latch div_quotient, div_remainder and div_error into the response registers → RESPOND.
  - No timeout.
- **RESPOND:**
  - rsp_valid=1, and every rsp_* output holds stable until rsp_ready=1.
  - When rsp_valid && rsp_ready, go to IDLE.
- **Operand stability:** div_numerator/div_denominator change only on an IDLE accept, so they are stable from LAUNCH through the done cycle. The divider reads operand signs at completion, so this stability is required.
- **div_done outside WAIT:** ignored, with no state change.
- **Pass-through results:** quotient, remainder and error are forwarded unmodified; the arbiter performs no arithmetic.
- **Divide-by-zero:** the divider reports div_error=1 and the arbiter forwards it as rsp_error=1. No special handling.
- **Requester-side handshake:**
  - req_valid may drop before it is accepted without consequence.
  - Requesters must hold operands stable while valid and unaccepted.

## Timing
- **Reset values:**
  - FSM state = IDLE and ptr=0, so requester 0 wins first.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_error=0.
  - div_start=0, div_numerator=0, div_denominator=0, busy=0.
- **Latency:** accept at edge T; div_start is high during cycle T+1. If div_done arrives D cycles after the start cycle, rsp_valid rises in the next cycle (start cycle + D + 1).
- **Throughput:** one request in flight. The next accept occurs at the earliest in the cycle after the response handshake.
- **Simultaneous requests:** exactly one grant per accept, and ptr rotates so a continuously valid requester is served within NUM_REQ transactions.
- **Reset mid-operation:** asynchronous return to IDLE with all outputs at reset values. Any in-flight result is discarded; the divider shares the same reset.
- **Backpressure:** rsp_ready low in RESPOND stalls indefinitely and no new request is accepted.

## Structure
- **Package div_arbiter_pkg:**
  - state_t enum {IDLE, LAUNCH, WAIT, RESPOND} in a 2-bit encoding.
  - Function next_rr(req_vector, ptr), returning the grant index and a found flag.
- **Sub-module rr_arbiter:** purely combinational round-robin priority select, parameterised by NUM_REQ. Inputs req and ptr; outputs grant_onehot, grant_idx and any_grant.
- **Top level:** FSM, operand/ID/result registers, and ptr register.

## Test plan
- **Single request:** requester 2 sends 100/7, rsp_ready=1 → one div_start pulse; rsp_id=2, quotient=14, remainder=2, error=0; latency matches the formula.
- **Signed operands:** requester 0 sends -100/7 → quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE).
- **Divide by zero:** requester 1 sends 5/0 → rsp_error=1, rsp_id=1, FSM back to IDLE after the handshake.
- **Fairness:** all four requesters hold req_valid with operands k*10/3 → grant order 0,1,2,3,0. Each response carries the correct id and quotient (0,3,6,10 for k=0..3).
- **Backpressure and spurious done:** hold rsp_ready=0 for 20 cycles with extra div_done pulses injected → rsp_* stable, no req_ready, no div_start; a single response is delivered when rsp_ready rises.
- **Reset mid-WAIT:** assert reset two cycles after div_start → all outputs at reset values, ptr=0, no response emitted. A new request afterwards completes normally.
